// File: rtl/delay_pkg.sv
// Shared helpers for the variable-tap delay line: width calculation and tap clamping.
package delay_pkg;

    // Smallest number of bits able to index 'value' distinct items.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    // Map a raw tap request onto a legal stage count in 1..depth.
    // A single-stage line has only one tap, so the request is ignored there.
    function automatic int tap_clamp(input int sel_val, input int depth);
        if (depth <= 1) begin
            return 1;
        end
        if (sel_val <= 0) begin
            return 1;
        end
        if (sel_val > depth) begin
            return depth;
        end
        return sel_val;
    endfunction

endpackage

// File: rtl/delay_stage.sv
// One register stage of the delay line: loads on enable, clears on a synchronous
// clear, and resets asynchronously when rst is low.
module delay_stage
    import delay_pkg::*;
#(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    // Next value: clear wins over load, otherwise hold.
    always_comb begin
        data_d = data_q;
        if (clr) begin
            data_d = '0;
        end else if (ena) begin
            data_d = d;
        end
    end

    // Stage register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/delay_line_var.sv
// Variable-tap delay line: DEPTH stages of {data, valid}, a saturating fill
// counter that drives 'full', and a combinational tap mux selected by 'sel'.
module delay_line_var
    import delay_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int SEL_W = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             flush,
    input  logic [WIDTH-1:0] dat_in,
    input  logic             vld_in,
    input  logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] dat_out,
    output logic             vld_out,
    output logic             full
);

    localparam logic [SEL_W-1:0] DEPTH_CNT = SEL_W'(DEPTH);

    // Each stage word packs data in the upper bits and the valid tag in bit 0.
    logic [WIDTH:0]   stage_in [DEPTH];
    logic [WIDTH:0]   stage_q  [DEPTH];
    logic [WIDTH:0]   tap_word;
    int               tap_idx;
    logic [SEL_W-1:0] count_q;
    logic [SEL_W-1:0] count_d;

    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_stage
            if (k == 0) begin : g_first
                assign stage_in[k] = {dat_in, vld_in};
            end else begin : g_rest
                assign stage_in[k] = stage_q[k-1];
            end

            delay_stage #(
                .W(WIDTH + 1)
            ) u_stage (
                .clk(clk),
                .rst(rst),
                .ena(ena),
                .clr(flush),
                .d  (stage_in[k]),
                .q  (stage_q[k])
            );
        end
    endgenerate

    // Tap mux: pick the stage whose output has seen the clamped number of shifts.
    always_comb begin
        tap_word = '0;
        tap_idx  = tap_clamp(int'(sel), DEPTH) - 1;
        for (int k = 0; k < DEPTH; k++) begin
            if (k == tap_idx) begin
                tap_word = stage_q[k];
            end
        end
    end

    // Fill count: cleared by flush, counts shifts, and sticks once the line is full.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (ena && (count_q != DEPTH_CNT)) begin
            count_d = count_q + SEL_W'(1);
        end
    end

    // Fill count register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign dat_out = tap_word[WIDTH:1];
    assign vld_out = tap_word[0];
    assign full    = (count_q == DEPTH_CNT);

endmodule

// File: tb/tb_delay_line_var.sv
// Testbench for delay_line_var: an 8x8 instance against a queue-based history
// model, plus a single-stage instance for the degenerate depth.
module tb_delay_line_var;

    localparam int W  = 8;
    localparam int D  = 8;
    localparam int SW = 4;

    logic          clk      = 1'b0;
    logic          rst      = 1'b0;
    logic          ena      = 1'b0;
    logic          flush    = 1'b0;
    logic [W-1:0]  dat_in   = '0;
    logic          vld_in   = 1'b0;
    logic [SW-1:0] sel      = 4'd1;
    logic [W-1:0]  dat_out;
    logic          vld_out;
    logic          full;

    logic          ena_1    = 1'b0;
    logic          flush_1  = 1'b0;
    logic [W-1:0]  dat_in_1 = '0;
    logic          vld_in_1 = 1'b0;
    logic [0:0]    sel_1    = 1'b0;
    logic [W-1:0]  dat_out_1;
    logic          vld_out_1;
    logic          full_1;

    int total = 0;
    int bad   = 0;

    // History of pushed {data, valid} words, newest first, trimmed to D entries.
    logic [W:0] hist0 [$];

    delay_line_var #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .ena(ena), .flush(flush),
        .dat_in(dat_in), .vld_in(vld_in), .sel(sel),
        .dat_out(dat_out), .vld_out(vld_out), .full(full)
    );

    delay_line_var #(.WIDTH(W), .DEPTH(1)) dut1 (
        .clk(clk), .rst(rst), .ena(ena_1), .flush(flush_1),
        .dat_in(dat_in_1), .vld_in(vld_in_1), .sel(sel_1),
        .dat_out(dat_out_1), .vld_out(vld_out_1), .full(full_1)
    );

    always #5 clk = ~clk;

    // Expected tap word: the word pushed t edges ago, or zero if the line is too short.
    function automatic logic [W:0] exp0();
        int t;
        if (sel == 0)           t = 1;
        else if (int'(sel) > D) t = D;
        else                    t = int'(sel);
        if (t <= hist0.size()) return hist0[t-1];
        return '0;
    endfunction

    // Advance one clock edge, update the model with the inputs seen at that edge, settle.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            if (flush) begin
                hist0.delete();
            end else if (ena) begin
                hist0.push_front({dat_in, vld_in});
                if (hist0.size() > D) void'(hist0.pop_back());
            end
        end
        #1;
    endtask

    task automatic test_reset();
        logic [W:0] e;
        #2;
        total++; if (dat_out !== 8'h00) begin bad++; $display("[TB] FAIL reset_dat got=%h exp=00", dat_out); end
        total++; if (vld_out !== 1'b0) begin bad++; $display("[TB] FAIL reset_vld got=%b exp=0", vld_out); end
        total++; if (full !== 1'b0) begin bad++; $display("[TB] FAIL reset_full got=%b exp=0", full); end
        @(negedge clk);
        rst = 1'b1;
        hist0.delete();
        dat_in = 8'h77; vld_in = 1'b1; ena = 1'b1; sel = 4'd1;
        step();
        e = exp0();
        total++; if ({dat_out, vld_out} !== e) begin bad++; $display("[TB] FAIL first_load got=%h/%b exp=%h/%b", dat_out, vld_out, e[W:1], e[0]); end
        flush = 1'b1; step(); flush = 1'b0; ena = 1'b0;
    endtask

    task automatic test_basic();
        logic [W:0] e;
        sel = 4'd3; ena = 1'b1; vld_in = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            dat_in = 8'(i);
            step();
            e = exp0();
            total++; if ({dat_out, vld_out} !== e) begin bad++; $display("[TB] FAIL basic_tap i=%0d got=%h/%b exp=%h/%b", i, dat_out, vld_out, e[W:1], e[0]); end
            total++; if (full !== (hist0.size() == D)) begin bad++; $display("[TB] FAIL basic_full i=%0d got=%b exp=%b", i, full, hist0.size() == D); end
            if (i == 3) begin
                total++; if (dat_out !== 8'h01 || vld_out !== 1'b1) begin bad++; $display("[TB] FAIL basic_third_edge got=%h/%b exp=01/1", dat_out, vld_out); end
            end
            if (i == 7) begin
                total++; if (full !== 1'b0) begin bad++; $display("[TB] FAIL basic_full_early got=%b exp=0", full); end
            end
            if (i == 8) begin
                total++; if (full !== 1'b1) begin bad++; $display("[TB] FAIL basic_full_8th got=%b exp=1", full); end
            end
        end
        ena = 1'b0;
        flush = 1'b1; step(); flush = 1'b0;
    endtask

    task automatic test_stall();
        logic [W:0] e;
        logic [W-1:0] held;
        logic [W-1:0] next_val;
        sel = 4'd3; vld_in = 1'b1; next_val = 8'h21;
        held = dat_out;
        for (int c = 1; c <= 9; c++) begin
            ena = !(c == 3 || c == 4);
            dat_in = next_val;
            step();
            if (ena) next_val = next_val + 8'h01;
            e = exp0();
            total++; if ({dat_out, vld_out} !== e) begin bad++; $display("[TB] FAIL stall_tap c=%0d got=%h/%b exp=%h/%b", c, dat_out, vld_out, e[W:1], e[0]); end
            if (c == 3 || c == 4) begin
                total++; if (dat_out !== held) begin bad++; $display("[TB] FAIL stall_hold c=%0d got=%h exp=%h", c, dat_out, held); end
            end
            if (c == 4) begin
                total++; if (vld_out !== 1'b0) begin bad++; $display("[TB] FAIL stall_early c=%0d got=%b exp=0", c, vld_out); end
            end
            if (c == 5) begin
                total++; if (dat_out !== 8'h21 || vld_out !== 1'b1) begin bad++; $display("[TB] FAIL stall_latency got=%h/%b exp=21/1", dat_out, vld_out); end
            end
            held = dat_out;
        end
        ena = 1'b0;
    endtask

    task automatic test_flush();
        logic [W:0] e;
        ena = 1'b1; vld_in = 1'b1; dat_in = 8'hA5;
        for (int i = 0; i < D; i++) step();
        total++; if (full !== 1'b1) begin bad++; $display("[TB] FAIL flush_prefull got=%b exp=1", full); end
        flush = 1'b1; ena = 1'b1; dat_in = 8'h3C;
        step();
        flush = 1'b0; ena = 1'b0;
        total++; if (vld_out !== 1'b0) begin bad++; $display("[TB] FAIL flush_vld got=%b exp=0", vld_out); end
        total++; if (dat_out !== 8'h00) begin bad++; $display("[TB] FAIL flush_dat got=%h exp=00", dat_out); end
        total++; if (full !== 1'b0) begin bad++; $display("[TB] FAIL flush_full got=%b exp=0", full); end
        for (int s = 1; s <= D; s++) begin
            sel = 4'(s);
            #1;
            e = exp0();
            total++; if ({dat_out, vld_out} !== e || dat_out === 8'hA5) begin bad++; $display("[TB] FAIL flush_residue sel=%0d got=%h/%b exp=%h/%b", s, dat_out, vld_out, e[W:1], e[0]); end
        end
    endtask

    task automatic test_sel_sweep();
        logic [SW-1:0] sels [4];
        logic [W-1:0]  exps [4];
        sels[0] = 4'd0;  exps[0] = 8'h17;
        sels[1] = 4'd1;  exps[1] = 8'h17;
        sels[2] = 4'd8;  exps[2] = 8'h10;
        sels[3] = 4'd15; exps[3] = 8'h10;
        flush = 1'b1; step(); flush = 1'b0;
        ena = 1'b1; vld_in = 1'b1;
        for (int i = 0; i < D; i++) begin
            dat_in = 8'h10 + 8'(i);
            step();
        end
        ena = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sel = sels[i];
            #1;
            total++; if (dat_out !== exps[i] || vld_out !== 1'b1) begin bad++; $display("[TB] FAIL sel_sweep sel=%0d got=%h/%b exp=%h/1", sels[i], dat_out, vld_out, exps[i]); end
        end
    endtask

    task automatic test_async_reset();
        sel = 4'd1; ena = 1'b1; vld_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dat_in = 8'($urandom_range(1, 255));
            step();
        end
        ena_1 = 1'b1; dat_in_1 = 8'h99; vld_in_1 = 1'b1;
        @(posedge clk); #1;
        ena_1 = 1'b0;
        hist0.delete();
        #2;
        rst = 1'b0;
        #1;
        total++; if (dat_out !== 8'h00 || vld_out !== 1'b0) begin bad++; $display("[TB] FAIL async_rst_out got=%h/%b exp=00/0", dat_out, vld_out); end
        total++; if (full !== 1'b0) begin bad++; $display("[TB] FAIL async_rst_full got=%b exp=0", full); end
        total++; if (dat_out_1 !== 8'h00 || vld_out_1 !== 1'b0 || full_1 !== 1'b0) begin bad++; $display("[TB] FAIL async_rst_d1 got=%h/%b/%b exp=00/0/0", dat_out_1, vld_out_1, full_1); end
        #1;
        rst = 1'b1;
        dat_in = 8'h5C; vld_in = 1'b1; ena = 1'b1;
        step();
        ena = 1'b0;
        total++; if (dat_out !== 8'h5C || vld_out !== 1'b1) begin bad++; $display("[TB] FAIL post_rst_stage0 got=%h/%b exp=5c/1", dat_out, vld_out); end
        sel = 4'd2;
        #1;
        total++; if (dat_out !== 8'h00 || vld_out !== 1'b0) begin bad++; $display("[TB] FAIL post_rst_stage1 got=%h/%b exp=00/0", dat_out, vld_out); end
        total++; if (full !== 1'b0) begin bad++; $display("[TB] FAIL post_rst_full got=%b exp=0", full); end
    endtask

    task automatic test_random();
        logic [W:0] e;
        for (int c = 0; c < 400; c++) begin
            ena    = ($urandom_range(0, 3) != 0);
            flush  = ($urandom_range(0, 15) == 0);
            dat_in = 8'($urandom);
            vld_in = 1'($urandom);
            sel    = 4'($urandom_range(0, 15));
            step();
            e = exp0();
            total++; if ({dat_out, vld_out} !== e) begin bad++; $display("[TB] FAIL rand_tap c=%0d sel=%0d got=%h/%b exp=%h/%b", c, sel, dat_out, vld_out, e[W:1], e[0]); end
            total++; if (full !== (hist0.size() == D)) begin bad++; $display("[TB] FAIL rand_full c=%0d got=%b exp=%b", c, full, hist0.size() == D); end
            sel = 4'($urandom_range(0, 15));
            #1;
            e = exp0();
            total++; if ({dat_out, vld_out} !== e) begin bad++; $display("[TB] FAIL rand_sel_change c=%0d sel=%0d got=%h/%b exp=%h/%b", c, sel, dat_out, vld_out, e[W:1], e[0]); end
        end
        ena = 1'b0; flush = 1'b0;
    endtask

    task automatic test_depth_one();
        logic [W-1:0] exp_d;
        logic         exp_v;
        ena_1 = 1'b1;
        for (int c = 0; c < 24; c++) begin
            dat_in_1 = 8'($urandom);
            vld_in_1 = 1'($urandom);
            sel_1    = 1'($urandom);
            exp_d    = dat_in_1;
            exp_v    = vld_in_1;
            step();
            total++; if (dat_out_1 !== exp_d || vld_out_1 !== exp_v) begin bad++; $display("[TB] FAIL depth1_tap c=%0d got=%h/%b exp=%h/%b", c, dat_out_1, vld_out_1, exp_d, exp_v); end
            total++; if (full_1 !== 1'b1) begin bad++; $display("[TB] FAIL depth1_full c=%0d got=%b exp=1", c, full_1); end
            sel_1 = ~sel_1;
            #1;
            total++; if (dat_out_1 !== exp_d) begin bad++; $display("[TB] FAIL depth1_sel_ignored c=%0d got=%h exp=%h", c, dat_out_1, exp_d); end
        end
        ena_1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_flush();
        test_sel_sweep();
        test_async_reset();
        test_random();
        test_depth_one();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/delay_line_var.md
DELAY_LINE_VAR -- requirements
Module: delay_line_var

Interface
- REQ-001 Parameter WIDTH, default 32: data bits per stage; legal range 1 or more.
- REQ-002 Parameter DEPTH, default 8: number of register stages; legal range 1 or more.
- REQ-003 Parameter SEL_W, default clog2(DEPTH+1): width of the tap-select port.
- REQ-004 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
- REQ-005 Port rst, input, 1: reset, asynchronous, active-low.
- REQ-006 Port ena, input, 1: advance enable; the line shifts one stage when high.
- REQ-007 Port flush, input, 1: synchronous clear of all stages.
- REQ-008 Port dat_in, input, WIDTH: data into stage 0.
- REQ-009 Port vld_in, input, 1: valid tag accompanying dat_in.
- REQ-010 Port sel, input, SEL_W: output tap select, in stages (1..DEPTH).
- REQ-011 Port dat_out, output, WIDTH: data at the selected tap.
- REQ-012 Port vld_out, output, 1: valid tag at the selected tap.
- REQ-013 Port full, output, 1: high when the fill count equals DEPTH.

Function
- REQ-014 Stage k (0..DEPTH-1) SHALL hold a WIDTH-bit data register and a 1-bit valid register.
- REQ-015 When ena=1 and flush=0, the line SHALL load stage0 with {dat_in, vld_in} and stage k with stage k-1, all in the same edge.
- REQ-016 When ena=0 and flush=0, all stages and the fill count SHALL hold their values.
- REQ-017 When flush=1, all data and valid registers and the fill count SHALL clear to 0 on the next edge, regardless of ena; flush has priority over ena.
- REQ-018 Tap index t SHALL be sel clamped: sel=0 gives t=1; sel>DEPTH gives t=DEPTH; otherwise t=sel.
- REQ-019 dat_out and vld_out SHALL be a combinational mux from stage t-1; no extra register.
- REQ-020 Latency SHALL be t ena-qualified edges from dat_in to dat_out; cycles with ena=0 do not count toward latency.
- REQ-021 A change of sel SHALL take effect in the same cycle; data already in the line is not altered.
- REQ-022 The fill count, width SEL_W, SHALL increment on each ena edge without flush and saturate at DEPTH.
- REQ-023 full SHALL be combinational from the fill count (count==DEPTH) and independent of vld_in values.
- REQ-024 With DEPTH=1, sel SHALL be ignored, and t=1.

Reset
- REQ-025 rst=0 SHALL asynchronously clear all data registers, valid registers and the fill count to 0.
- REQ-026 During reset, dat_out, vld_out and full SHALL be 0; a reset asserted mid-stream discards all in-flight data.
- REQ-027 After reset deasserts, the first ena edge SHALL load stage0 normally.

Structure
- REQ-028 A shared package delay_pkg SHALL hold the clog2 helper function and the tap-clamp function used for REQ-018.
- REQ-029 One sub-module, delay_stage (WIDTH+1 bits, ena, synchronous clear, asynchronous active-low reset), SHALL be instantiated DEPTH times via generate.
- REQ-030 The fill counter and the tap mux SHALL live in delay_line_var.

Verification
- REQ-031 WIDTH=8, DEPTH=8, sel=3, ena=1, dat_in 0x01,0x02,... with vld_in=1 -> dat_out=0x01 with vld_out=1 on the third edge; full rises after the 8th edge.
- REQ-032 sel=3 stream with ena=0 for 2 cycles mid-stream -> dat_out holds its value; latency to dat_out is 3 ena edges plus 2 stalled cycles.
- REQ-033 Line full with 0xA5 in all stages; flush=1 together with ena=1 -> next cycle vld_out=0, dat_out=0x00, full=0; the 0xA5 values do not reappear.
- REQ-034 sel sweep 0, 1, 8, 15 on a filled line -> taps 1, 1, 8, 8 respectively, in the same cycle as the sel change.
- REQ-035 rst pulsed low for a partial cycle mid-stream, asynchronous to clk -> all outputs 0 immediately; the first ena after release sets stage0 only.
- REQ-036 DEPTH=1, sel held at any value -> dat_out follows dat_in with a one-edge delay.
